// File: rtl/tdpr_port_arbiter.sv
// tdpr_port_arbiter
//   Shares one true dual-port RAM (two synchronous ports, 1-cycle read
//   latency) among NUM_REQ requesters. After reset, the block zero-fills the
//   RAM two words per cycle. It then grants up to two requests per cycle in
//   round-robin order, one per RAM port. Read data is routed back to the
//   requester that issued the read.
//   Optional build macro: TDPR_ARB_STATS_EN adds the stat_grants and
//   stat_collisions counters and ports.

module tdpr_port_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int DATA_SIZE = 8,
  parameter int NUM_REQ   = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             rvalid,
  output logic [NUM_REQ*DATA_SIZE-1:0]   rdata,
  output logic                           init_done,
  output logic                           en_a,
  output logic                           we_a,
  output logic [ADDR_SIZE-1:0]           addr_a,
  output logic [DATA_SIZE-1:0]           din_a,
  input  logic [DATA_SIZE-1:0]           dout_a,
  output logic                           en_b,
  output logic                           we_b,
  output logic [ADDR_SIZE-1:0]           addr_b,
  output logic [DATA_SIZE-1:0]           din_b,
  input  logic [DATA_SIZE-1:0]           dout_b
`ifdef TDPR_ARB_STATS_EN
  ,
  output logic [31:0]                    stat_grants,
  output logic [15:0]                    stat_collisions
`endif
);

  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // The fill counter indexes word pairs, so it is one bit narrower than an address.
  localparam int CW  = ADDR_SIZE - 1;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic                 rd_vld_a_q, rd_vld_a_d;
  logic                 rd_vld_b_q, rd_vld_b_d;
  logic [IDW-1:0]       rd_own_a_q, rd_own_a_d;
  logic [IDW-1:0]       rd_own_b_q, rd_own_b_d;
  logic [DATA_SIZE-1:0] rdata_q [NUM_REQ];
  logic [DATA_SIZE-1:0] rdata_d [NUM_REQ];

  logic [ADDR_SIZE-1:0] addr_arr  [NUM_REQ];
  logic [DATA_SIZE-1:0] wdata_arr [NUM_REQ];

  logic                 run;
  logic                 a_found, b_found;
  logic [IDW-1:0]       a_idx, b_idx;
  logic                 collide;
  logic                 grant_a, grant_b;

  // Returns (base + off) mod NUM_REQ. The caller keeps off below NUM_REQ.
  function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

  // Unpack the per-requester address and write-data buses.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_SIZE +: ADDR_SIZE];
      wdata_arr[i] = req_wdata[i*DATA_SIZE +: DATA_SIZE];
    end
  end

  // Scan requests cyclically from ptr. The first hit takes port A and the
  // second hit takes port B.
  // NOTE: every always_comb output gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (req[wrap_idx(ptr_q, off)]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = wrap_idx(ptr_q, off);
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = wrap_idx(ptr_q, off);
        end
      end
    end
  end

  // Collision: both ports use the same address and at least one of them
  // writes. Port B then stays idle for this cycle.
  always_comb begin
    run     = (state_q == ST_RUN);
    collide = run && a_found && b_found &&
              (addr_arr[a_idx] == addr_arr[b_idx]) &&
              (req_we[a_idx] || req_we[b_idx]);
    grant_a = run && a_found;
    grant_b = run && b_found && !collide;
  end

  // Combinational grant vector. This is 0 outside RUN, which includes reset.
  always_comb begin
    gnt = '0;
    if (grant_a) gnt[a_idx] = 1'b1;
    if (grant_b) gnt[b_idx] = 1'b1;
  end

  // Drive the RAM ports. INIT writes zeros to an even/odd word pair each
  // cycle. RUN copies the controls of the requester that owns each port.
  always_comb begin
    en_a   = 1'b0;
    we_a   = 1'b0;
    addr_a = '0;
    din_a  = '0;
    en_b   = 1'b0;
    we_b   = 1'b0;
    addr_b = '0;
    din_b  = '0;
    if (state_q == ST_INIT) begin
      if (rst_n) begin
        en_a   = 1'b1;
        we_a   = 1'b1;
        addr_a = {cnt_q, 1'b0};
        en_b   = 1'b1;
        we_b   = 1'b1;
        addr_b = {cnt_q, 1'b1};
      end
    end else begin
      if (grant_a) begin
        en_a   = 1'b1;
        we_a   = req_we[a_idx];
        addr_a = addr_arr[a_idx];
        din_a  = wdata_arr[a_idx];
      end
      if (grant_b) begin
        en_b   = 1'b1;
        we_b   = req_we[b_idx];
        addr_b = addr_arr[b_idx];
        din_b  = wdata_arr[b_idx];
      end
    end
  end

  // Next-state logic for the FSM, the fill counter and the round-robin pointer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (collide)      ptr_d = b_idx;  // the deferred requester leads next cycle
        else if (grant_b) ptr_d = wrap_idx(b_idx, 1);
        else if (grant_a) ptr_d = wrap_idx(a_idx, 1);
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Record which requester owns each read that is now in flight.
  always_comb begin
    rd_vld_a_d = grant_a && !req_we[a_idx];
    rd_own_a_d = a_idx;
    rd_vld_b_d = grant_b && !req_we[b_idx];
    rd_own_b_d = b_idx;
  end

  // Route RAM read data to its owner and hold the last value for everyone else.
  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      rvalid[r]  = 1'b0;
      rdata_d[r] = rdata_q[r];
      if (rd_vld_a_q && (rd_own_a_q == IDW'(r))) begin
        rvalid[r]  = 1'b1;
        rdata_d[r] = dout_a;
      end
      if (rd_vld_b_q && (rd_own_b_q == IDW'(r))) begin
        rvalid[r]  = 1'b1;
        rdata_d[r] = dout_b;
      end
      rdata[r*DATA_SIZE +: DATA_SIZE] = rdata_d[r];
    end
  end

  assign init_done = (state_q == ST_RUN);

  // State registers. An asynchronous reset abandons in-flight reads and
  // restarts the fill.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of block ordering.
  // NOTE: the rdata hold array is a few flops rather than a RAM, so it is
  // reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      cnt_q      <= '0;
      ptr_q      <= '0;
      rd_vld_a_q <= 1'b0;
      rd_vld_b_q <= 1'b0;
      rd_own_a_q <= '0;
      rd_own_b_q <= '0;
      for (int r = 0; r < NUM_REQ; r++) rdata_q[r] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
      rd_vld_a_q <= rd_vld_a_d;
      rd_vld_b_q <= rd_vld_b_d;
      rd_own_a_q <= rd_own_a_d;
      rd_own_b_q <= rd_own_b_d;
      for (int r = 0; r < NUM_REQ; r++) rdata_q[r] <= rdata_d[r];
    end
  end

`ifdef TDPR_ARB_STATS_EN
  logic [31:0] stat_grants_q, stat_grants_d;
  logic [15:0] stat_collisions_q, stat_collisions_d;

  // Grant count wraps. Collision count saturates at all-ones.
  always_comb begin
    stat_grants_d     = stat_grants_q + 32'(grant_a) + 32'(grant_b);
    stat_collisions_d = stat_collisions_q;
    if (collide && (stat_collisions_q != 16'hFFFF)) stat_collisions_d = stat_collisions_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants_q     <= '0;
      stat_collisions_q <= '0;
    end else begin
      stat_grants_q     <= stat_grants_d;
      stat_collisions_q <= stat_collisions_d;
    end
  end

  assign stat_grants     = stat_grants_q;
  assign stat_collisions = stat_collisions_q;
`endif

endmodule

// File: tb/tb_tdpr_port_arbiter.sv
// tb_tdpr_port_arbiter
//   Scoreboard bench for tdpr_port_arbiter with its default parameters.
//   A behavioural dual-port RAM sits behind the DUT, and a reference memory
//   predicts read data. Expected reads are queued when a grant is predicted
//   and are consumed when rvalid appears.

module tb_tdpr_port_arbiter;

  localparam int A = 8;
  localparam int D = 8;
  localparam int N = 4;

  typedef struct packed {
    logic [1:0]   id;
    logic [D-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [N-1:0]   req, req_we;
  logic [A-1:0]   t_addr  [N];
  logic [D-1:0]   t_wdata [N];
  logic [N*A-1:0] req_addr;
  logic [N*D-1:0] req_wdata;

  logic [N-1:0]   gnt, rvalid;
  logic [N*D-1:0] rdata;
  logic           init_done;
  logic           en_a, we_a, en_b, we_b;
  logic [A-1:0]   addr_a, addr_b;
  logic [D-1:0]   din_a, din_b, dout_a, dout_b;
`ifdef TDPR_ARB_STATS_EN
  logic [31:0]    stat_grants;
  logic [15:0]    stat_collisions;
`endif

  logic [D-1:0]   mem     [1<<A];
  logic [D-1:0]   ref_mem [1<<A];
  exp_t           exp_q [$];
  exp_t           mon_e;

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_addr[g*A +: A]  = t_addr[g];
    assign req_wdata[g*D +: D] = t_wdata[g];
  end

  tdpr_port_arbiter #(.ADDR_SIZE(A), .DATA_SIZE(D), .NUM_REQ(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .init_done (init_done),
    .en_a      (en_a),
    .we_a      (we_a),
    .addr_a    (addr_a),
    .din_a     (din_a),
    .dout_a    (dout_a),
    .en_b      (en_b),
    .we_b      (we_b),
    .addr_b    (addr_b),
    .din_b     (din_b),
    .dout_b    (dout_b)
`ifdef TDPR_ARB_STATS_EN
    ,
    .stat_grants     (stat_grants),
    .stat_collisions (stat_collisions)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural true dual-port RAM with a 1-cycle read.
  always @(posedge clk) begin
    if (en_a) begin
      if (we_a) mem[addr_a] <= din_a;
      else      dout_a <= mem[addr_a];
    end
    if (en_b) begin
      if (we_b) mem[addr_b] <= din_b;
      else      dout_b <= mem[addr_b];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Read-return monitor: each rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    for (int r = 0; r < N; r++) begin
      if (rvalid[r]) begin
        if (exp_q.size() == 0) begin
          check($sformatf("unexpected_rvalid%0d", r), 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rd_owner", r, 32'(mon_e.id));
          check($sformatf("rdata%0d", r), 32'(rdata[r*D +: D]), 32'(mon_e.data));
        end
      end
    end
  end

  task automatic clear_req();
    req    = '0;
    req_we = '0;
    for (int i = 0; i < N; i++) begin
      t_addr[i]  = '0;
      t_wdata[i] = '0;
    end
  endtask

  task automatic set_req(input int id, input logic we, input logic [A-1:0] addr, input logic [D-1:0] wd);
    req[id]     = 1'b1;
    req_we[id]  = we;
    t_addr[id]  = addr;
    t_wdata[id] = wd;
  endtask

  // Called just after a negedge once the inputs are set. Compares the port
  // controls {en,we,addr,din} of both RAM ports.
  task automatic chk_ports(input string tag, input logic [17:0] exp_a, input logic [17:0] exp_b);
    #1;
    check({tag, "_port_a"}, 32'({en_a, we_a, addr_a, din_a}), 32'(exp_a));
    check({tag, "_port_b"}, 32'({en_b, we_b, addr_b, din_b}), 32'(exp_b));
  endtask

  // Check the combinational grant and, when track is set, queue the predicted
  // read results and apply the predicted writes. Then advance one clock.
  task automatic step(input string tag, input logic [N-1:0] exp_gnt, input bit track);
    #1;
    check({"gnt_", tag}, 32'(gnt), 32'(exp_gnt));
    if (track) begin
      for (int r = 0; r < N; r++)
        if (exp_gnt[r] && !req_we[r]) exp_q.push_back({2'(r), ref_mem[t_addr[r]]});
      for (int r = 0; r < N; r++)
        if (exp_gnt[r] && req_we[r]) ref_mem[t_addr[r]] = t_wdata[r];
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Count clocks from reset release until init_done rises. The wait is bounded.
  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 1000) begin
      @(negedge clk);
      n++;
      if (n == 64) begin
        req = '1;
        #1;
        check({tag, "_gnt_in_init"}, 32'(gnt), 32'd0);
        check({tag, "_fill_mid_a"}, 32'({en_a, we_a, addr_a, din_a}), 32'({2'b11, 8'd128, 8'd0}));
        check({tag, "_fill_mid_b"}, 32'({en_b, we_b, addr_b, din_b}), 32'({2'b11, 8'd129, 8'd0}));
        clear_req();
      end
    end
    check({tag, "_cycles"}, n, 32'd128);
  endtask

  initial begin
    clear_req();
    for (int i = 0; i < (1 << A); i++) begin
      mem[i]     = 8'($urandom) | 8'h01;
      ref_mem[i] = '0;
    end

    // Reset: all outputs are quiet even when requests are present.
    repeat (3) @(negedge clk);
    req = '1;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_ctrl", 32'({en_a, we_a, en_b, we_b}), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    clear_req();
    @(negedge clk);
    rst_n = 1'b1;
    chk_ports("fill_k0", {2'b11, 8'd0, 8'd0}, {2'b11, 8'd1, 8'd0});
    wait_init("init1");

    // Read every address back; each must be zero after the fill.
    for (int i = 0; i < (1 << A) / 2; i++) begin
      clear_req();
      set_req(0, 1'b0, 8'(2*i), '0);
      set_req(1, 1'b0, 8'(2*i + 1), '0);
      step("fill_rd", 4'b0011, 1'b1);
    end

    // A write on port A and a read on port B in the same cycle.
    clear_req();
    set_req(0, 1'b1, 8'h10, 8'hA5);
    set_req(1, 1'b0, 8'h20, 8'h00);
    chk_ports("wr_rd", {2'b11, 8'h10, 8'hA5}, {2'b10, 8'h20, 8'h00});
    step("wr_rd", 4'b0011, 1'b1);
    check("rvalid_wr_rd", 32'(rvalid), 32'b0010);

    // Same-address write/read collision from ptr=2: port B is deferred.
    clear_req();
    set_req(2, 1'b1, 8'h33, 8'h5A);
    set_req(3, 1'b0, 8'h33, 8'h00);
    chk_ports("coll", {2'b11, 8'h33, 8'h5A}, 18'd0);
    step("coll", 4'b0100, 1'b1);
    clear_req();
    set_req(3, 1'b0, 8'h33, 8'h00);
    chk_ports("coll_def", {2'b10, 8'h33, 8'h00}, 18'd0);
    step("coll_def", 4'b1000, 1'b1);
`ifdef TDPR_ARB_STATS_EN
    check("stat_collisions", 32'(stat_collisions), 32'd1);
    check("stat_grants", stat_grants, 32'd260);
`endif

    // All four requesters held for 4 cycles from ptr=0.
    clear_req();
    for (int r = 0; r < N; r++) set_req(r, 1'b0, 8'(8'h80 + r), '0);
    step("rr0", 4'b0011, 1'b1);
    step("rr1", 4'b1100, 1'b1);
    step("rr2", 4'b0011, 1'b1);
    step("rr3", 4'b1100, 1'b1);

    // Write on port B, then read it back on port A.
    clear_req();
    set_req(0, 1'b0, 8'h50, '0);
    set_req(1, 1'b1, 8'h51, 8'hC3);
    chk_ports("b_wr", {2'b10, 8'h50, 8'h00}, {2'b11, 8'h51, 8'hC3});
    step("b_wr", 4'b0011, 1'b1);
    clear_req();
    set_req(2, 1'b0, 8'h51, '0);
    step("b_rd", 4'b0100, 1'b1);

    // Two reads of the same address are both granted (ptr=3 -> then 1).
    clear_req();
    set_req(0, 1'b1, 8'h40, 8'h3C);
    step("wr40", 4'b0001, 1'b1);
    clear_req();
    set_req(1, 1'b0, 8'h40, '0);
    set_req(2, 1'b0, 8'h40, '0);
    step("rd_pair", 4'b0110, 1'b1);
    check("rvalid_pair", 32'(rvalid), 32'b0110);
    check("rdata_pair_eq", 32'(rdata[1*D +: D]), 32'(rdata[2*D +: D]));

    // A read is pending when reset hits: it must never return.
    clear_req();
    set_req(0, 1'b0, 8'h10, '0);
    #1;
    check("gnt_abort_rd", 32'(gnt), 32'b0001);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_rvalid", 32'(rvalid), 32'd0);
    check("abort_gnt", 32'(gnt), 32'd0);
    check("abort_ctrl", 32'({en_a, we_a, en_b, we_b}), 32'd0);
    check("abort_init_done", 32'(init_done), 32'd0);
    clear_req();
    for (int i = 0; i < (1 << A); i++) ref_mem[i] = '0;
    @(negedge clk);
    @(negedge clk);
`ifdef TDPR_ARB_STATS_EN
    check("stat_grants_rst", stat_grants, 32'd0);
    check("stat_coll_rst", 32'(stat_collisions), 32'd0);
`endif
    rst_n = 1'b1;
    wait_init("init2");

    // The refill cleared the earlier write to 0x10.
    clear_req();
    set_req(0, 1'b0, 8'h10, '0);
    step("rd_after_refill", 4'b0001, 1'b1);
    clear_req();

    repeat (2) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
